// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its checkers: op-code encodings and the
// checker's run-state encoding.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [2:0] ALU_ADD = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_ILL = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/alu_golden_model.sv
// Combinational reference model of the 32-bit ALU: golden result, zero bit,
// and a flag for the unused op code.
module alu_golden_model
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] expected_result,
  output logic        expected_zero,
  output logic        illegal_op
);

  always_comb begin
    expected_result = 32'd0;
    illegal_op      = 1'b0;
    case (op)
      ALU_AND: expected_result = a & b;
      ALU_OR:  expected_result = a | b;
      ALU_XOR: expected_result = a ^ b;
      ALU_NOR: expected_result = ~(a | b);
      ALU_SLT: expected_result = {31'd0, ($signed(a) < $signed(b))};
      ALU_ADD: expected_result = a + b;
      ALU_SUB: expected_result = a - b;
      default: illegal_op      = 1'b1;
    endcase
    expected_zero = (expected_result == 32'd0);
  end

endmodule

// File: rtl/alu_result_checker.sv
// In-hardware checker for ALU observations: two-stage compare pipeline,
// saturating pass/fail tallies and a sticky first-mismatch capture.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             finish,
  input  logic             obs_valid,
  input  logic [31:0]      obs_a,
  input  logic [31:0]      obs_b,
  input  logic [2:0]       obs_op,
  input  logic [31:0]      obs_result,
  input  logic             obs_zero,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_index,
  output logic [2:0]       first_fail_op,
  output logic [31:0]      first_fail_expected,
  output logic [31:0]      first_fail_observed,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [1:0]       dbg_state
);

  state_t state_q, state_d;

  logic        s1_valid_q, s1_valid_d;
  logic [31:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2:0]  s1_op_q, s1_op_d;
  logic [31:0] s1_result_q, s1_result_d;
  logic        s1_zero_q, s1_zero_d;

  logic        s2_valid_q, s2_valid_d;
  logic        s2_fail_q, s2_fail_d;
  logic [2:0]  s2_op_q, s2_op_d;
  logic [31:0] s2_expected_q, s2_expected_d;
  logic [31:0] s2_observed_q, s2_observed_d;

  logic [CNT_W-1:0] pass_q, pass_d, fail_q, fail_d, idx_q, idx_d;
  logic             ff_valid_q, ff_valid_d;
  logic [CNT_W-1:0] ff_index_q, ff_index_d;
  logic [2:0]       ff_op_q, ff_op_d;
  logic [31:0]      ff_exp_q, ff_exp_d, ff_obs_q, ff_obs_d;

  logic [31:0] gold_result;
  logic        gold_zero;
  logic        gold_illegal;
  logic        accept;
  logic        commit;

  alu_golden_model u_golden (
    .a               (s1_a_q),
    .b               (s1_b_q),
    .op              (s1_op_q),
    .expected_result (gold_result),
    .expected_zero   (gold_zero),
    .illegal_op      (gold_illegal)
  );

  // start takes priority over everything: it drops a same-cycle sample and
  // any sample retiring on this edge.
  assign accept = (state_q == RUN) && obs_valid && !start;
  assign commit = s2_valid_q && !start;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (finish) state_d = DRAIN;
        // Stage 2 retires on this same edge, so only stage 1 gates exit.
        DRAIN:   if (!s1_valid_q) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    s1_valid_d  = accept;
    s1_a_d      = accept ? obs_a      : s1_a_q;
    s1_b_d      = accept ? obs_b      : s1_b_q;
    s1_op_d     = accept ? obs_op     : s1_op_q;
    s1_result_d = accept ? obs_result : s1_result_q;
    s1_zero_d   = accept ? obs_zero   : s1_zero_q;

    s2_valid_d    = s1_valid_q && !start;
    s2_fail_d     = (s1_result_q != gold_result) || (s1_zero_q != gold_zero) || gold_illegal;
    s2_op_d       = s1_op_q;
    s2_expected_d = gold_result;
    s2_observed_d = s1_result_q;
  end

  always_comb begin
    pass_d     = pass_q;
    fail_d     = fail_q;
    idx_d      = idx_q;
    ff_valid_d = ff_valid_q;
    ff_index_d = ff_index_q;
    ff_op_d    = ff_op_q;
    ff_exp_d   = ff_exp_q;
    ff_obs_d   = ff_obs_q;
    if (start) begin
      pass_d     = '0;
      fail_d     = '0;
      idx_d      = '0;
      ff_valid_d = 1'b0;
      ff_index_d = '0;
      ff_op_d    = 3'd0;
      ff_exp_d   = 32'd0;
      ff_obs_d   = 32'd0;
    end else if (commit) begin
      idx_d = idx_q + CNT_W'(1);
      if (s2_fail_q) begin
        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
        if (!ff_valid_q) begin
          ff_valid_d = 1'b1;
          ff_index_d = idx_q;
          ff_op_d    = s2_op_q;
          ff_exp_d   = s2_expected_q;
          ff_obs_d   = s2_observed_q;
        end
      end else begin
        if (pass_q != '1) pass_d = pass_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      s1_valid_q    <= 1'b0;
      s1_a_q        <= 32'd0;
      s1_b_q        <= 32'd0;
      s1_op_q       <= 3'd0;
      s1_result_q   <= 32'd0;
      s1_zero_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_fail_q     <= 1'b0;
      s2_op_q       <= 3'd0;
      s2_expected_q <= 32'd0;
      s2_observed_q <= 32'd0;
      pass_q        <= '0;
      fail_q        <= '0;
      idx_q         <= '0;
      ff_valid_q    <= 1'b0;
      ff_index_q    <= '0;
      ff_op_q       <= 3'd0;
      ff_exp_q      <= 32'd0;
      ff_obs_q      <= 32'd0;
    end else begin
      state_q       <= state_d;
      s1_valid_q    <= s1_valid_d;
      s1_a_q        <= s1_a_d;
      s1_b_q        <= s1_b_d;
      s1_op_q       <= s1_op_d;
      s1_result_q   <= s1_result_d;
      s1_zero_q     <= s1_zero_d;
      s2_valid_q    <= s2_valid_d;
      s2_fail_q     <= s2_fail_d;
      s2_op_q       <= s2_op_d;
      s2_expected_q <= s2_expected_d;
      s2_observed_q <= s2_observed_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
      idx_q         <= idx_d;
      ff_valid_q    <= ff_valid_d;
      ff_index_q    <= ff_index_d;
      ff_op_q       <= ff_op_d;
      ff_exp_q      <= ff_exp_d;
      ff_obs_q      <= ff_obs_d;
    end
  end

  assign pass_count          = pass_q;
  assign fail_count          = fail_q;
  assign first_fail_valid    = ff_valid_q;
  assign first_fail_index    = ff_index_q;
  assign first_fail_op       = ff_op_q;
  assign first_fail_expected = ff_exp_q;
  assign first_fail_observed = ff_obs_q;
  assign busy                = (state_q == RUN) || (state_q == DRAIN);
  assign done                = (state_q == DONE);
  assign all_pass            = done && (fail_q == '0) && (pass_q != '0);
  assign dbg_state           = state_q;

endmodule

// File: tb/tb_alu_result_checker.sv
// Directed bench for alu_result_checker: the driver pushes the expected tally
// snapshot per sample, a monitor pops it when the sample retires.
module tb_alu_result_checker;
  import alu_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] pass_cnt;
    logic [W-1:0] fail_cnt;
    logic         ffv;
    logic [W-1:0] ff_idx;
    logic [2:0]   ff_op;
    logic [31:0]  ff_exp;
    logic [31:0]  ff_obs;
  } exp_t;

  // Clock/reset and stimulus signals
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, finish = 1'b0;
  logic        start4 = 1'b0, finish4 = 1'b0;
  logic        obs_valid = 1'b0;
  logic [31:0] obs_a = 32'd0, obs_b = 32'd0, obs_result = 32'd0;
  logic [2:0]  obs_op = 3'd0;
  logic        obs_zero = 1'b0;

  logic [W-1:0] pass_count, fail_count, first_fail_index;
  logic         first_fail_valid, busy, done, all_pass;
  logic [2:0]   first_fail_op;
  logic [31:0]  first_fail_expected, first_fail_observed;
  logic [1:0]   dbg_state;

  logic [3:0]   p4, f4, ffi4;
  logic         ffv4, busy4, done4, ap4;
  logic [2:0]   ffo4;
  logic [31:0]  ffe4, ffobs4;
  logic [1:0]   dbg4;

  // Scoreboard state
  exp_t exp_q[$];
  exp_t model;
  exp_t last_exp;
  logic [W-1:0] m_idx;
  logic ev_sample = 1'b0, ev_clear = 1'b1;
  logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, c1 = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_result_checker #(.CNT_W(W)) u_dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .obs_valid(obs_valid), .obs_a(obs_a), .obs_b(obs_b), .obs_op(obs_op),
    .obs_result(obs_result), .obs_zero(obs_zero),
    .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_valid(first_fail_valid), .first_fail_index(first_fail_index),
    .first_fail_op(first_fail_op), .first_fail_expected(first_fail_expected),
    .first_fail_observed(first_fail_observed),
    .busy(busy), .done(done), .all_pass(all_pass), .dbg_state(dbg_state)
  );

  alu_result_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .finish(finish4),
    .obs_valid(obs_valid), .obs_a(obs_a), .obs_b(obs_b), .obs_op(obs_op),
    .obs_result(obs_result), .obs_zero(obs_zero),
    .pass_count(p4), .fail_count(f4),
    .first_fail_valid(ffv4), .first_fail_index(ffi4),
    .first_fail_op(ffo4), .first_fail_expected(ffe4),
    .first_fail_observed(ffobs4),
    .busy(busy4), .done(done4), .all_pass(ap4), .dbg_state(dbg4)
  );

  // Expected retirement timing: a sample retires on the third edge after it
  // is driven; start/reset flush whatever is still in flight.
  always @(posedge clk) begin
    c1 <= ev_clear;
    if (ev_clear) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
      d3 <= 1'b0;
    end else begin
      d1 <= ev_sample;
      d2 <= d1;
      d3 <= d2;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, req);
    end
  endtask

  function automatic exp_t dut_snapshot();
    exp_t s;
    s.pass_cnt = pass_count;
    s.fail_cnt = fail_count;
    s.ffv      = first_fail_valid;
    s.ff_idx   = first_fail_index;
    s.ff_op    = first_fail_op;
    s.ff_exp   = first_fail_expected;
    s.ff_obs   = first_fail_observed;
    return s;
  endfunction

  task automatic chk_sb(input string name, input exp_t req);
    exp_t act;
    act = dut_snapshot();
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual pass=%0d fail=%0d ffv=%0b idx=%0d op=%0d exp=%h obs=%h required pass=%0d fail=%0d ffv=%0b idx=%0d op=%0d exp=%h obs=%h",
               name, act.pass_cnt, act.fail_cnt, act.ffv, act.ff_idx, act.ff_op, act.ff_exp, act.ff_obs,
               req.pass_cnt, req.fail_cnt, req.ffv, req.ff_idx, req.ff_op, req.ff_exp, req.ff_obs);
    end
  endtask

  // Monitor: checks once per cycle, just after the active edge.
  initial begin
    last_exp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (c1) begin
        last_exp = '0;
        chk_sb("clear", last_exp);
      end else if (d3) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow actual=empty expected=entry");
        end else begin
          last_exp = exp_q.pop_front();
          chk_sb("retire", last_exp);
        end
      end else begin
        chk_sb("hold", last_exp);
      end
    end
  end

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0; finish = 1'b0; start4 = 1'b0; finish4 = 1'b0;
      obs_valid = 1'b0; ev_sample = 1'b0; ev_clear = 1'b0;
    end
  endtask

  task automatic clear_model();
    model = '0;
    m_idx = '0;
    exp_q.delete();
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] res, input logic z, input logic is_fail,
                      input logic [31:0] gold, input logic with_finish, input logic track);
    @(negedge clk);
    start = 1'b0; start4 = 1'b0; ev_clear = 1'b0;
    finish = with_finish; finish4 = 1'b0;
    obs_valid = 1'b1; obs_op = op; obs_a = a; obs_b = b; obs_result = res; obs_zero = z;
    ev_sample = track;
    if (track) begin
      if (is_fail) begin
        model.fail_cnt = model.fail_cnt + 1'b1;
        if (!model.ffv) begin
          model.ffv    = 1'b1;
          model.ff_idx = m_idx;
          model.ff_op  = op;
          model.ff_exp = gold;
          model.ff_obs = res;
        end
      end else begin
        model.pass_cnt = model.pass_cnt + 1'b1;
      end
      m_idx = m_idx + 1'b1;
      exp_q.push_back(model);
    end
  endtask

  task automatic do_start(input logic with_finish, input logic with_obs);
    @(negedge clk);
    start = 1'b1; finish = with_finish; start4 = 1'b0; finish4 = 1'b0;
    obs_valid = with_obs; obs_op = ALU_ADD; obs_a = 32'd1; obs_b = 32'd1;
    obs_result = 32'd9; obs_zero = 1'b0;
    ev_sample = 1'b0; ev_clear = 1'b1;
    clear_model();
  endtask

  task automatic do_finish();
    @(negedge clk);
    start = 1'b0; finish = 1'b1; start4 = 1'b0; finish4 = 1'b0;
    obs_valid = 1'b0; ev_sample = 1'b0; ev_clear = 1'b0;
  endtask

  task automatic do_reset(input int n);
    repeat (n) begin
      @(negedge clk);
      reset = 1'b1; start = 1'b0; finish = 1'b0; obs_valid = 1'b0;
      ev_sample = 1'b0; ev_clear = 1'b1;
      clear_model();
    end
    @(negedge clk);
    reset = 1'b0; ev_clear = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 10) begin
      idle(1);
      n++;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    // Reset, then samples while IDLE must be ignored
    do_reset(3);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_all_pass", {31'd0, all_pass}, 32'd0);
    send(ALU_ADD, 32'd1, 32'd1, 32'd5, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0);
    send(ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 32'd2, 1'b0, 1'b0);
    idle(3);

    // Two back-to-back passes
    do_start(1'b0, 1'b0);
    send(ALU_ADD, 32'd15, 32'd12, 32'd27, 1'b0, 1'b0, 32'd27, 1'b0, 1'b1);
    chk("run_busy", {31'd0, busy}, 32'd1);
    send(ALU_SUB, 32'd15, 32'd15, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    do_finish();
    wait_done("done_run1");
    chk("run1_all_pass", {31'd0, all_pass}, 32'd1);
    chk("run1_busy", {31'd0, busy}, 32'd0);
    idle(2);

    // Mixed run with several mismatch kinds; last sample rides with finish
    do_start(1'b0, 1'b0);
    send(ALU_AND, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 1'b0, 1'b0, 32'h000F000F, 1'b0, 1'b1);
    send(ALU_SUB, 32'd15, 32'd22, 32'd7, 1'b0, 1'b1, 32'hFFFFFFF9, 1'b0, 1'b1);
    send(ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, 32'd1, 1'b0, 1'b1);
    send(ALU_SLT, 32'd15, 32'd12, 32'd1, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    send(ALU_XOR, 32'h12345678, 32'h12345678, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 1'b1);
    send(ALU_ILL, 32'd3, 32'd4, 32'd0, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
    send(ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, 1'b0, 32'hFF, 1'b1, 1'b1);
    wait_done("done_run2");
    chk("run2_all_pass", {31'd0, all_pass}, 32'd0);
    chk("run2_fail_count", {16'd0, fail_count}, 32'd4);
    idle(2);

    // start from DONE clears; then reset with samples in flight
    do_start(1'b0, 1'b0);
    send(ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b1);
    send(ALU_NOR, 32'd0, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1);
    idle(3);
    send(ALU_ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 32'd3, 1'b0, 1'b1);
    send(ALU_SUB, 32'd5, 32'd3, 32'd2, 1'b0, 1'b0, 32'd2, 1'b0, 1'b1);
    do_reset(1);
    chk("midreset_busy", {31'd0, busy}, 32'd0);
    chk("midreset_done", {31'd0, done}, 32'd0);
    idle(3);

    // start with finish and obs_valid in the same cycle: start wins, sample dropped
    do_start(1'b1, 1'b1);
    idle(1);
    chk("start_wins_busy", {31'd0, busy}, 32'd1);
    chk("start_wins_done", {31'd0, done}, 32'd0);
    idle(2);
    send(ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 32'd5, 1'b1, 1'b1);
    wait_done("done_run4");
    chk("run4_all_pass", {31'd0, all_pass}, 32'd1);
    chk("run4_pass_count", {16'd0, pass_count}, 32'd1);
    idle(2);

    // Narrow-counter instance: saturation and index wrap
    @(negedge clk);
    start4 = 1'b1; obs_valid = 1'b0; ev_sample = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      send(ALU_ADD, i, 32'd1, i + 1, 1'b0, 1'b0, i + 1, 1'b0, 1'b0);
    end
    send(ALU_ADD, 32'd2, 32'd2, 32'd5, 1'b0, 1'b1, 32'd4, 1'b0, 1'b0);
    @(negedge clk);
    obs_valid = 1'b0; finish4 = 1'b1;
    for (int n = 0; n < 10 && !done4; n++) idle(1);
    chk("cnt4_done", {31'd0, done4}, 32'd1);
    chk("cnt4_pass_sat", {28'd0, p4}, 32'd15);
    chk("cnt4_fail", {28'd0, f4}, 32'd1);
    chk("cnt4_ff_index_wrap", {28'd0, ffi4}, 32'd4);
    chk("cnt4_ff_expected", ffe4, 32'd4);
    chk("cnt4_all_pass", {31'd0, ap4}, 32'd0);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_checker.md
Name: alu_result_checker

Overview:
- Synthesizable, self-checking receiver for the 32-bit ALU's outputs.
- A stimulus source drives operand/op/observed-result tuples into it. The block recomputes the golden result and zero bit internally, then compares them against the observed values.
- It keeps saturating pass/fail tallies and a sticky capture of the first mismatch.
- It sits beside the ALU in bench and bring-up builds, so ALU sequences are checked in hardware instead of by reading a display log.

Parameters:
- CNT_W, 16: width of the sample index, pass counter and fail counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse: clear all tallies and captures, enter RUN
- finish  in  1  one-cycle pulse: end the run after the pipeline drains
- obs_valid  in  1  observation tuple valid this cycle
- obs_a  in  32  operand A driven to the ALU
- obs_b  in  32  operand B driven to the ALU
- obs_op  in  3  ALU op code driven to the ALU
- obs_result  in  32  result observed from the ALU
- obs_zero  in  1  zero bit observed from the ALU
- pass_count  out  CNT_W  matching samples
- fail_count  out  CNT_W  mismatching samples
- first_fail_valid  out  1  sticky: a mismatch has been captured
- first_fail_index  out  CNT_W  sample index of the first mismatch
- first_fail_op  out  3  op code of the first mismatch
- first_fail_expected  out  32  golden result of the first mismatch
- first_fail_observed  out  32  observed result of the first mismatch
- busy  out  1  high in RUN or DRAIN
- done  out  1  high in DONE
- all_pass  out  1  done && fail_count==0 && pass_count!=0

Behaviour:
- Reset, whether synchronous or arriving mid-run:
  - FSM goes to IDLE; the pipeline valid bits are cleared.
  - All counters, the sample index and all first_fail_* outputs go to 0.
  - busy, done and all_pass are 0.
- Golden model, by op:
  - 000 AND; 001 OR; 010 XOR; 011 NOR.
  - 100 SLT: signed 32-bit compare; result = {31'b0, a<b}.
  - 101 ADD and 110 SUB: modulo 2^32; carry and overflow are ignored.
  - 111 is illegal: the sample always counts as a fail, with expected = 0.
- Expected zero = (expected result == 0), for every op.
- Mismatch = (obs_result != expected) OR (obs_zero != expected zero) OR (op == 111).
- Pipeline: two stages.
  - Stage 1 registers the tuple when obs_valid is high and the FSM is in RUN.
  - Stage 2 registers the expected result/zero and the compare flag.
  - Counters and captures update on the edge ending stage 2.
  - A sample with obs_valid in cycle N is reflected in the outputs after edge N+2.
  - One sample per cycle is sustained; there is no backpressure.
- Sample index: starts at 0 and increments once per accepted sample. It wraps modulo 2^CNT_W.
- Counters: pass_count and fail_count saturate at all-ones and never wrap.
- First-fail capture:
  - Captured only when first_fail_valid is 0; it holds until start or reset.
  - Once it holds, later mismatches change only fail_count.
- FSM states:
  - IDLE: obs_valid is ignored. start -> RUN.
  - RUN: samples are accepted. finish -> DRAIN.
  - DRAIN: no new samples are accepted. When both stage-valid bits are 0 -> DONE; this is at most 2 cycles.
  - DONE: outputs hold. start -> RUN.
- start in any state clears tallies and captures, flushes the pipeline and enters RUN.
- start and finish in the same cycle: start wins.
- obs_valid in the same cycle as finish (in RUN) is accepted as the last sample.
- obs_valid in the same cycle as start is dropped.
- Outputs are read at any time. Counters are live during RUN and frozen in DONE.

Decomposition:
- Shared package alu_pkg:
  - localparams for the op codes: ALU_AND=3'b000, ALU_OR=3'b001, ALU_XOR=3'b010, ALU_NOR=3'b011, ALU_SLT=3'b100, ALU_ADD=3'b101, ALU_SUB=3'b110.
  - FSM state encodings: IDLE, RUN, DRAIN, DONE.
- One sub-module, alu_golden_model: purely combinational (a, b, op) -> (expected_result, expected_zero, illegal_op). It is reusable by other benches.
- The FSM, pipeline and counters stay in the top module.

Test Plan:
- start; then, back to back: ADD a=15,b=12,result=27,zero=0; SUB 15,15,result=0,zero=1; finish
  -> DONE; pass_count=2, fail_count=0, all_pass=1, first_fail_valid=0.
- start; AND a=0x0F0F0F0F,b=0x00FF00FF,result=0x000F000F; then SUB a=15,b=22,result=7,zero=0
  -> pass_count=1, fail_count=1, first_fail_index=1, first_fail_op=110, expected=0xFFFFFFF9, observed=7.
- SLT a=0xFFFFFFFF,b=1,result=1 -> pass (signed). SLT a=15,b=12,result=1 -> fail, expected=0.
- XOR a=b=0x12345678, result=0, zero=0 -> fail on the zero bit only.
- op=111 with any result -> fail.
- A second mismatch after the first leaves first_fail_* unchanged.
- Single sample at cycle N
  -> counter changes after edge N+2, not before.
- Reset asserted mid-RUN with samples in flight -> all outputs 0, IDLE.
- obs_valid while IDLE is ignored.
- start in DONE clears all outputs.
- CNT_W=4: 20 passing samples
  -> pass_count=15 (saturated); index wraps to 4 after the 20th sample.
